// File: rtl/seg_display_arbiter_if.sv
// Bus between the display requesters and the seg_display_arbiter.
// The requester side drives requests and values; the arbiter drives grant and display value.
interface seg_display_arbiter_if;
    logic [3:0]   req_in;
    logic [127:0] val_in;
    logic [3:0]   grant_out;
    logic [1:0]   owner_out;
    logic         valid_out;
    logic [31:0]  val_out;

    modport master (
        output req_in,
        output val_in,
        input  grant_out,
        input  owner_out,
        input  valid_out,
        input  val_out
    );

    modport slave (
        input  req_in,
        input  val_in,
        output grant_out,
        output owner_out,
        output valid_out,
        output val_out
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment display among four requesters.
// Each grant is held at least HOLD_CYCLES before another requester may preempt it.
module seg_display_arbiter #(
    parameter logic [31:0] HOLD_CYCLES = 32'd100_000_000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    seg_display_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  rr_ptr, rr_ptr_nxt;
    logic [1:0]  owner, owner_nxt;
    logic [31:0] hold_cnt, hold_cnt_nxt;
    logic [3:0]  grant, grant_nxt;
    logic        valid, valid_nxt;
    logic [31:0] val, val_nxt;

    logic [1:0]  winner;
    logic        win_found;
    logic        others_req;
    logic        release_now;
    logic [1:0]  idx;

    // Search rr_ptr+3 down to rr_ptr so the index closest to rr_ptr wins last.
    always_comb begin
        winner    = rr_ptr;
        win_found = 1'b0;
        idx       = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_ptr + 2'(i);
            if (bus.req_in[idx]) begin
                winner    = idx;
                win_found = 1'b1;
            end
        end
    end

    assign others_req  = |(bus.req_in & ~(4'b0001 << owner));
    assign release_now = (state == HOLD) &&
                         (!bus.req_in[owner] || ((hold_cnt == HOLD_CYCLES) && others_req));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            owner    <= 2'd0;
            hold_cnt <= 32'd0;
            grant    <= 4'd0;
            valid    <= 1'b0;
            val      <= 32'd0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            owner    <= owner_nxt;
            hold_cnt <= hold_cnt_nxt;
            grant    <= grant_nxt;
            valid    <= valid_nxt;
            val      <= val_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win_found) state_nxt = HOLD;
            HOLD:    if (release_now) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output of this block gets a hold-value default first so no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        rr_ptr_nxt   = rr_ptr;
        owner_nxt    = owner;
        hold_cnt_nxt = hold_cnt;
        grant_nxt    = grant;
        valid_nxt    = valid;
        val_nxt      = val;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    grant_nxt    = 4'b0001 << winner;
                    owner_nxt    = winner;
                    valid_nxt    = 1'b1;
                    val_nxt      = bus.val_in[{winner, 5'b0} +: 32];
                    hold_cnt_nxt = 32'd0;
                    rr_ptr_nxt   = winner + 2'd1;
                end
            end
            HOLD: begin
                hold_cnt_nxt = (hold_cnt == HOLD_CYCLES) ? hold_cnt : hold_cnt + 32'd1;
                if (release_now) begin
                    grant_nxt = 4'd0;
                    valid_nxt = 1'b0;
                end else begin
                    val_nxt = bus.val_in[{owner, 5'b0} +: 32];
                end
            end
            default: ;
        endcase
    end

    assign bus.grant_out = grant;
    assign bus.owner_out = owner;
    assign bus.valid_out = valid;
    assign bus.val_out   = val;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with HOLD_CYCLES=3: a vector table
// for the main sequence plus hand-written round-robin, hold, tie and reset cases.
module tb_seg_display_arbiter;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    seg_display_arbiter_if bus ();

    seg_display_arbiter #(.HOLD_CYCLES(32'd3)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0]   req;
        logic [127:0] val;
        logic [3:0]   exp_grant;
        logic [1:0]   exp_owner;
        logic         exp_valid;
        logic [31:0]  exp_val;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic [3:0] req, input logic [31:0] v3, input logic [31:0] v2,
                                input logic [31:0] v1, input logic [31:0] v0, input logic [3:0] eg,
                                input logic [1:0] eo, input logic ev, input logic [31:0] eval);
        vec_t v;
        v.req = req; v.val = {v3, v2, v1, v0};
        v.exp_grant = eg; v.exp_owner = eo; v.exp_valid = ev; v.exp_val = eval;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] o,
                              input logic v, input logic [31:0] d);
        check({tag, ".grant"}, 32'(bus.grant_out), 32'(g));
        check({tag, ".owner"}, 32'(bus.owner_out), 32'(o));
        check({tag, ".valid"}, 32'(bus.valid_out), 32'(v));
        check({tag, ".val"},   bus.val_out, d);
    endtask

    task automatic apply_reset();
        bus.req_in = 4'd0;
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    initial begin
        bus.req_in = 4'd0;
        bus.val_in = '0;

        // Main sequence: single grant, tracking, release, early release, preemption.
        tbl[0]  = mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 2'd0, 1'b0, 32'h0);
        tbl[1]  = mk(4'b0001, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 4'b0001, 2'd0, 1'b1, 32'hDEADBEEF);
        tbl[2]  = mk(4'b0001, 32'h0, 32'h0, 32'h0, 32'h12345678, 4'b0001, 2'd0, 1'b1, 32'h12345678);
        tbl[3]  = mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h55555555, 4'b0000, 2'd0, 1'b0, 32'h12345678);
        tbl[4]  = mk(4'b0100, 32'h0, 32'hCAFE0002, 32'h0, 32'h0, 4'b0000, 2'd0, 1'b0, 32'h12345678);
        tbl[5]  = mk(4'b0100, 32'h0, 32'hCAFE0002, 32'h0, 32'h0, 4'b0100, 2'd2, 1'b1, 32'hCAFE0002);
        tbl[6]  = mk(4'b1100, 32'h00000003, 32'hCAFE0002, 32'h0, 32'h0, 4'b0100, 2'd2, 1'b1, 32'hCAFE0002);
        tbl[7]  = mk(4'b1000, 32'h00000003, 32'hCAFE0002, 32'h0, 32'h0, 4'b0000, 2'd2, 1'b0, 32'hCAFE0002);
        tbl[8]  = mk(4'b1000, 32'h00000003, 32'h0, 32'h0, 32'h0, 4'b0000, 2'd2, 1'b0, 32'hCAFE0002);
        tbl[9]  = mk(4'b1000, 32'h00000003, 32'h0, 32'h0, 32'h0, 4'b1000, 2'd3, 1'b1, 32'h00000003);
        tbl[10] = mk(4'b1001, 32'h00000003, 32'h0, 32'h0, 32'hAAAA0000, 4'b1000, 2'd3, 1'b1, 32'h00000003);
        tbl[11] = mk(4'b1001, 32'h00000033, 32'h0, 32'h0, 32'hAAAA0000, 4'b1000, 2'd3, 1'b1, 32'h00000033);
        tbl[12] = mk(4'b1001, 32'h00000033, 32'h0, 32'h0, 32'hAAAA0000, 4'b1000, 2'd3, 1'b1, 32'h00000033);
        tbl[13] = mk(4'b1001, 32'h00000077, 32'h0, 32'h0, 32'hAAAA0000, 4'b0000, 2'd3, 1'b0, 32'h00000033);
        tbl[14] = mk(4'b1001, 32'h00000077, 32'h0, 32'h0, 32'hAAAA0000, 4'b0000, 2'd3, 1'b0, 32'h00000033);
        tbl[15] = mk(4'b1001, 32'h00000077, 32'h0, 32'h0, 32'hAAAA0000, 4'b0001, 2'd0, 1'b1, 32'hAAAA0000);
        tbl[16] = mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'hBBBB0000, 4'b0000, 2'd0, 1'b0, 32'hAAAA0000);
        tbl[17] = mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 2'd0, 1'b0, 32'hAAAA0000);
        tbl[18] = mk(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 2'd0, 1'b0, 32'hAAAA0000);

        apply_reset();
        check_outs("reset", 4'b0000, 2'd0, 1'b0, 32'h0);

        for (int i = 0; i < 19; i++) begin
            bus.req_in = tbl[i].req;
            bus.val_in = tbl[i].val;
            step();
            check_outs($sformatf("vec%0d", i), tbl[i].exp_grant, tbl[i].exp_owner,
                       tbl[i].exp_valid, tbl[i].exp_val);
        end

        // Round-robin with all four requesting: 4 granted cycles then 2 idle cycles each.
        apply_reset();
        bus.val_in = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        bus.req_in = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                check($sformatf("rr%0d.grant", g), 32'(bus.grant_out), 32'(4'b0001 << (g % 4)));
                check($sformatf("rr%0d.owner", g), 32'(bus.owner_out), 32'(g % 4));
            end
            if (g < 4) begin
                for (int c = 0; c < 2; c++) begin
                    step();
                    check($sformatf("rr%0d.gap", g), 32'(bus.grant_out), 32'd0);
                end
            end
        end

        // No preemption without contention, then contention after saturation.
        apply_reset();
        bus.val_in = {32'h0, 32'h44440000, 32'h0, 32'h0000AAAA};
        bus.req_in = 4'b0100;
        for (int c = 0; c < 50; c++) begin
            step();
            check("solo.grant", 32'(bus.grant_out), 32'(4'b0100));
        end
        bus.req_in = 4'b0101;
        step();
        check("preempt.release", 32'(bus.grant_out), 32'd0);
        step();
        check("preempt.gap", 32'(bus.grant_out), 32'd0);
        step();
        check_outs("preempt.new", 4'b0001, 2'd0, 1'b1, 32'h0000AAAA);

        // Owner drop and preemption on the same edge give a single release.
        apply_reset();
        bus.val_in = {32'h0, 32'h0, 32'h11110000, 32'h0000FFFF};
        bus.req_in = 4'b0010;
        for (int c = 0; c < 4; c++) step();
        check("tie.held", 32'(bus.grant_out), 32'(4'b0010));
        bus.req_in = 4'b0001;
        step();
        check("tie.release", 32'(bus.grant_out), 32'd0);
        step();
        check("tie.gap", 32'(bus.grant_out), 32'd0);
        step();
        check_outs("tie.new", 4'b0001, 2'd0, 1'b1, 32'h0000FFFF);
        step();
        check("tie.keep", 32'(bus.grant_out), 32'(4'b0001));

        // Asynchronous reset mid-grant, then idle with no requests.
        #2;
        rst_in = 1'b1;
        #1;
        check_outs("async_rst", 4'b0000, 2'd0, 1'b0, 32'h0);
        step();
        bus.req_in = 4'b0000;
        rst_in = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            check_outs("idle", 4'b0000, 2'd0, 1'b0, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
